// File: rtl/zx_bus_if.sv
// CPU-side bus bundle between the bus master and the ULA, plus its command/response handshake.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready for commands; rsp_valid is a one-cycle pulse with no ready.
interface zx_bus_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] xa;
    logic [7:0]  xd_o;
    logic        xd_oe;
    logic [7:0]  xd_i;
    logic        n_mreq;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic        n_m1;
    logic        n_rfsh;
    logic        n_wait;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, xd_i, n_wait,
        output cmd_ready, rsp_valid, rsp_rdata, xa, xd_o, xd_oe,
               n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, xd_i, n_wait,
        input  cmd_ready, rsp_valid, rsp_rdata, xa, xd_o, xd_oe,
               n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh
    );
endinterface

// File: rtl/zx_bus_master.sv
// Z80 bus initiator: runs one M1 / memory / I/O machine cycle per accepted command.
// Latency: T1 starts at the first cpu_p after acceptance; read data returns at p3 (M1) or n3.
// Backpressure: cmd_ready is high only in IDLE with nothing pending; one cycle in flight.
module zx_bus_master #(
    parameter int RFSH_W      = 7,
    parameter int IO_AUTOWAIT = 1
) (
    input  logic     clk28,
    input  logic     rst,
    input  logic     cpu_p,
    input  logic     cpu_n,
    zx_bus_if.master bus
);
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

    typedef struct packed {
        logic [15:0] xa;
        logic [7:0]  xd_o;
        logic        xd_oe;
        logic        n_mreq;
        logic        n_iorq;
        logic        n_rd;
        logic        n_wr;
        logic        n_m1;
        logic        n_rfsh;
    } bus_out_t;

    localparam logic [2:0] OP_M1  = 3'd0;
    localparam logic [2:0] OP_MRD = 3'd1;
    localparam logic [2:0] OP_MWR = 3'd2;
    localparam logic [2:0] OP_IOR = 3'd3;
    localparam logic [2:0] OP_IOW = 3'd4;
    localparam logic [3:0] AUTOWAIT = 4'(IO_AUTOWAIT);
    localparam bus_out_t BUS_IDLE = '{xa: 16'h0000, xd_o: 8'h00, xd_oe: 1'b0, n_mreq: 1'b1,
                                      n_iorq: 1'b1, n_rd: 1'b1, n_wr: 1'b1, n_m1: 1'b1, n_rfsh: 1'b1};

    state_t            state_q, state_nx;
    logic              pend_q, pend_nx;
    logic [2:0]        op_q, op_nx;
    logic [15:0]       addr_q, addr_nx;
    logic [7:0]        wdata_q, wdata_nx;
    logic              wait_q, wait_nx;     // last sampled wait request: one more TW needed
    logic [3:0]        tw_q, tw_nx;         // forced I/O wait states already spent
    logic [RFSH_W-1:0] rfsh_q, rfsh_nx;
    logic              ready_q, ready_nx;
    logic              rvalid_q, rvalid_nx;
    logic [7:0]        rdata_q, rdata_nx;
    bus_out_t          out_q, out_nx;
    logic              is_io;
    logic              go_t3;

    assign is_io = (op_q == OP_IOR) || (op_q == OP_IOW);

    // State and bus registers; reset drops every strobe on the same clk28 edge.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            op_q     <= OP_M1;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            wait_q   <= 1'b0;
            tw_q     <= 4'd0;
            rfsh_q   <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'h00;
            out_q    <= BUS_IDLE;
        end else begin
            state_q  <= state_nx;
            pend_q   <= pend_nx;
            op_q     <= op_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
            wait_q   <= wait_nx;
            tw_q     <= tw_nx;
            rfsh_q   <= rfsh_nx;
            ready_q  <= ready_nx;
            rvalid_q <= rvalid_nx;
            rdata_q  <= rdata_nx;
            out_q    <= out_nx;
        end
    end

    // T-state sequencing and strobe updates, advanced only on cpu_p (priority) or cpu_n.
    always_comb begin
        state_nx  = state_q;
        pend_nx   = pend_q;
        op_nx     = op_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        wait_nx   = wait_q;
        tw_nx     = tw_q;
        rfsh_nx   = rfsh_q;
        rdata_nx  = rdata_q;
        rvalid_nx = 1'b0;
        out_nx    = out_q;
        go_t3     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_q && bus.cmd_valid) begin
                    op_nx    = bus.cmd_op;
                    addr_nx  = bus.cmd_addr;
                    wdata_nx = bus.cmd_wdata;
                    // Reserved opcodes are swallowed without touching the bus.
                    pend_nx  = (bus.cmd_op <= OP_IOW);
                end else if (pend_q && cpu_p) begin
                    state_nx    = T1;
                    pend_nx     = 1'b0;
                    wait_nx     = 1'b0;
                    tw_nx       = 4'd0;
                    out_nx.xa   = addr_q;
                    out_nx.n_m1 = (op_q != OP_M1);
                    if (op_q == OP_MWR || op_q == OP_IOW) begin
                        out_nx.xd_o  = wdata_q;
                        out_nx.xd_oe = 1'b1;
                    end
                end
            end
            T1: begin
                if (cpu_p) begin
                    state_nx = T2;
                    if (is_io) begin
                        out_nx.n_iorq = 1'b0;
                        out_nx.n_rd   = (op_q != OP_IOR);
                        out_nx.n_wr   = (op_q != OP_IOW);
                    end
                end else if (cpu_n && !is_io) begin
                    out_nx.n_mreq = 1'b0;
                    out_nx.n_rd   = (op_q == OP_MWR);
                end
            end
            T2: begin
                if (cpu_p) begin
                    if (is_io && AUTOWAIT != 4'd0) begin
                        state_nx = TW;
                        tw_nx    = 4'd1;
                    end else if (wait_q) begin
                        state_nx = TW;
                    end else begin
                        go_t3 = 1'b1;
                    end
                end else if (cpu_n) begin
                    if (!is_io || AUTOWAIT == 4'd0) wait_nx = !bus.n_wait;
                    if (op_q == OP_MWR) out_nx.n_wr = 1'b0;
                end
            end
            TW: begin
                if (cpu_p) begin
                    if (is_io && tw_q < AUTOWAIT) tw_nx = tw_q + 4'd1;
                    else if (!wait_q)             go_t3 = 1'b1;
                end else if (cpu_n) begin
                    // I/O only listens to n_wait from the last forced TW onward.
                    if (!is_io || tw_q >= AUTOWAIT) wait_nx = !bus.n_wait;
                end
            end
            T3: begin
                if (cpu_p) begin
                    if (op_q == OP_M1) begin
                        state_nx = T4;
                    end else begin
                        state_nx     = IDLE;
                        out_nx.xd_oe = 1'b0;
                    end
                end else if (cpu_n) begin
                    if (op_q == OP_M1) begin
                        out_nx.n_mreq = 1'b0;
                    end else begin
                        out_nx.n_mreq = 1'b1;
                        out_nx.n_iorq = 1'b1;
                        out_nx.n_rd   = 1'b1;
                        out_nx.n_wr   = 1'b1;
                        if (op_q == OP_MRD || op_q == OP_IOR) begin
                            rdata_nx  = bus.xd_i;
                            rvalid_nx = 1'b1;
                        end
                    end
                end
            end
            T4: begin
                if (cpu_p) begin
                    state_nx      = IDLE;
                    out_nx.n_rfsh = 1'b1;
                    rfsh_nx       = rfsh_q + 1'b1;
                end else if (cpu_n) begin
                    out_nx.n_mreq = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Entering T3: an M1 fetch latches the opcode here and switches to refresh.
        if (go_t3) begin
            state_nx = T3;
            if (op_q == OP_M1) begin
                rdata_nx      = bus.xd_i;
                rvalid_nx     = 1'b1;
                out_nx.n_mreq = 1'b1;
                out_nx.n_rd   = 1'b1;
                out_nx.n_m1   = 1'b1;
                out_nx.n_rfsh = 1'b0;
                out_nx.xa     = 16'(rfsh_q);
            end
        end

        ready_nx = (state_nx == IDLE) && !pend_nx;
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rvalid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.xa        = out_q.xa;
    assign bus.xd_o      = out_q.xd_o;
    assign bus.xd_oe     = out_q.xd_oe;
    assign bus.n_mreq    = out_q.n_mreq;
    assign bus.n_iorq    = out_q.n_iorq;
    assign bus.n_rd      = out_q.n_rd;
    assign bus.n_wr      = out_q.n_wr;
    assign bus.n_m1      = out_q.n_m1;
    assign bus.n_rfsh    = out_q.n_rfsh;
endmodule

// File: tb/tb_zx_bus_master.sv
// Directed bench for zx_bus_master: each cycle is measured as strobe-low widths in clk28 cycles.
// clkcpu = clk28/8, so one T-state is 8 clk28 cycles and a half period is 4.
// n_wait is pulled low only on chosen cpu_n strobes (index 1 = n1 of the cycle).
module tb_zx_bus_master;
    logic       clk28 = 1'b0;
    logic       rst   = 1'b1;
    logic [2:0] ph    = 3'd0;
    logic       cpu_p;
    logic       cpu_n;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          wfrom, wlen;
        int          pst, m1, mreq, iorq, rd, wr, rfsh, oe, rsp;
        logic [7:0]  rexp;
        int          rfa;
    } vec_t;

    typedef struct {
        int         pst, m1, mreq, iorq, rd, wr, rfsh, oe, rsp, xa, rfa, xdbad, timeout;
        logic [7:0] rdata;
    } meas_t;

    always #5 clk28 = ~clk28;
    always @(posedge clk28) ph <= ph + 3'd1;
    assign cpu_p = (ph == 3'd0);
    assign cpu_n = (ph == 3'd4);

    zx_bus_if bus();

    zx_bus_master #(.RFSH_W(7), .IO_AUTOWAIT(1)) dut (
        .clk28 (clk28),
        .rst   (rst),
        .cpu_p (cpu_p),
        .cpu_n (cpu_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic [2:0] op, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic [7:0] rdata,
                                input int wfrom, input int wlen, input int pst, input int m1,
                                input int mreq, input int iorq, input int rd, input int wr,
                                input int rfsh, input int oe, input int rsp,
                                input logic [7:0] rexp, input int rfa);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.wfrom = wfrom; v.wlen = wlen; v.pst = pst; v.m1 = m1; v.mreq = mreq;
        v.iorq = iorq; v.rd = rd; v.wr = wr; v.rfsh = rfsh; v.oe = oe; v.rsp = rsp;
        v.rexp = rexp; v.rfa = rfa;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d (0x%0h), expected %0d (0x%0h)", name, idx, act, act, exp, exp);
        end
    endtask

    // Issue one command and watch the bus until cmd_ready returns.
    task automatic apply(input vec_t v, output meas_t m);
        int guard;
        int pc;
        int nc;
        bit got_xa;
        bit got_rf;
        m = '{default: 0, rdata: 8'h00};
        @(negedge clk28);
        bus.cmd_op = v.op; bus.cmd_addr = v.addr; bus.cmd_wdata = v.wdata;
        bus.xd_i = v.rdata; bus.n_wait = 1'b1; bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin @(negedge clk28); guard++; end
        @(negedge clk28);
        bus.cmd_valid = 1'b0;
        guard = 0; pc = 0; nc = 0; got_xa = 0; got_rf = 0;
        while (!bus.cmd_ready && guard < 400) begin
            if (!bus.n_m1)   m.m1++;
            if (!bus.n_mreq) m.mreq++;
            if (!bus.n_iorq) m.iorq++;
            if (!bus.n_rd)   m.rd++;
            if (!bus.n_wr)   m.wr++;
            if (!bus.n_rfsh) m.rfsh++;
            if (bus.xd_oe)   m.oe++;
            if (bus.rsp_valid) m.rsp++;
            if (bus.xd_oe && bus.xd_o != v.wdata) m.xdbad++;
            if (!got_xa && (!bus.n_mreq || !bus.n_iorq)) begin m.xa = int'(bus.xa); got_xa = 1; end
            if (!got_rf && !bus.n_rfsh) begin m.rfa = int'(bus.xa); got_rf = 1; end
            if (cpu_p) pc++;
            if (cpu_n && pc >= 1) nc++;
            bus.n_wait = !(cpu_n && pc >= 1 && nc >= v.wfrom && nc < v.wfrom + v.wlen);
            @(negedge clk28);
            guard++;
        end
        bus.n_wait = 1'b1;
        if (bus.rsp_valid) m.rsp++;
        m.timeout = (guard >= 400) ? 1 : 0;
        m.pst = pc;
        m.rdata = bus.rsp_rdata;
    endtask

    task automatic check_vec(input int i, input vec_t v, input meas_t m);
        chk("timeout", i, m.timeout, 0);
        chk("cpu_p_count", i, m.pst, v.pst);
        chk("n_m1_low", i, m.m1, v.m1);
        chk("n_mreq_low", i, m.mreq, v.mreq);
        chk("n_iorq_low", i, m.iorq, v.iorq);
        chk("n_rd_low", i, m.rd, v.rd);
        chk("n_wr_low", i, m.wr, v.wr);
        chk("n_rfsh_low", i, m.rfsh, v.rfsh);
        chk("xd_oe_high", i, m.oe, v.oe);
        chk("rsp_valid_count", i, m.rsp, v.rsp);
        chk("rsp_rdata", i, int'(m.rdata), int'(v.rexp));
        chk("xd_o_bad", i, m.xdbad, 0);
        if (v.op <= 3'd4) chk("xa_cycle", i, m.xa, int'(v.addr));
        if (v.rfa >= 0)   chk("xa_refresh", i, m.rfa, v.rfa);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[12];
        vec_t  v;
        meas_t m;
        int    guard;
        int    rsp_seen;

        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_addr = 16'h0000;
        bus.cmd_wdata = 8'h00; bus.xd_i = 8'h00; bus.n_wait = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk28);
        chk("rst_cmd_ready", 0, bus.cmd_ready, 0);
        chk("rst_strobes", 0, int'({bus.n_mreq, bus.n_iorq, bus.n_rd, bus.n_wr, bus.n_m1, bus.n_rfsh}), 63);
        chk("rst_xa", 0, int'(bus.xa), 0);
        chk("rst_xd_o", 0, int'(bus.xd_o), 0);
        chk("rst_xd_oe", 0, bus.xd_oe, 0);
        chk("rst_rsp_valid", 0, bus.rsp_valid, 0);
        chk("rst_rsp_rdata", 0, int'(bus.rsp_rdata), 0);
        rst = 1'b0;
        @(negedge clk28);
        chk("cmd_ready_after_rst", 0, bus.cmd_ready, 1);

        //         op    addr      wd     xd_i  wf wl pst m1 mreq iorq rd wr rfsh oe rsp rexp  rfa
        vt[0]  = mk(3'd0, 16'h1234, 8'h00, 8'h3E, 0, 0, 5, 16, 20, 0, 12, 0, 16, 0, 1, 8'h3E, 0);
        vt[1]  = mk(3'd0, 16'h0100, 8'h00, 8'hC3, 2, 1, 6, 24, 28, 0, 20, 0, 16, 0, 1, 8'hC3, 1);
        vt[2]  = mk(3'd2, 16'h5800, 8'hA5, 8'h00, 0, 0, 4,  0, 16, 0,  0, 8,  0, 24, 0, 8'hC3, -1);
        vt[3]  = mk(3'd1, 16'h4000, 8'h00, 8'h7F, 2, 2, 6,  0, 32, 0, 32, 0,  0, 0, 1, 8'h7F, -1);
        vt[4]  = mk(3'd1, 16'h4001, 8'h00, 8'h11, 1, 1, 4,  0, 16, 0, 16, 0,  0, 0, 1, 8'h11, -1);
        vt[5]  = mk(3'd3, 16'h00FE, 8'h00, 8'hBF, 0, 0, 5,  0,  0, 20, 20, 0, 0, 0, 1, 8'hBF, -1);
        vt[6]  = mk(3'd3, 16'h7FFE, 8'h00, 8'h5A, 2, 1, 5,  0,  0, 20, 20, 0, 0, 0, 1, 8'h5A, -1);
        vt[7]  = mk(3'd3, 16'hFEFE, 8'h00, 8'h1F, 3, 1, 6,  0,  0, 28, 28, 0, 0, 0, 1, 8'h1F, -1);
        vt[8]  = mk(3'd4, 16'h00FE, 8'h07, 8'h00, 0, 0, 5,  0,  0, 20, 0, 20, 0, 32, 0, 8'h1F, -1);
        vt[9]  = mk(3'd5, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, 8'h1F, -1);
        vt[10] = mk(3'd7, 16'hAAAA, 8'h55, 8'h00, 0, 0, 0,  0,  0, 0,  0, 0,  0, 0, 0, 8'h1F, -1);
        vt[11] = mk(3'd1, 16'hFFFF, 8'h00, 8'h00, 0, 0, 4,  0, 16, 0, 16, 0,  0, 0, 1, 8'h00, -1);

        for (int i = 0; i < 12; i++) begin
            apply(vt[i], m);
            check_vec(i, vt[i], m);
        end

        // Back-to-back fetches: counter starts at 2, so i=125 shows 0x7F and i=126 wraps to 0.
        for (int i = 0; i < 128; i++) begin
            v = mk(3'd0, 16'h8000 + 16'(i), 8'h00, 8'(i), 0, 0, 5, 16, 20, 0, 12, 0, 16, 0, 1, 8'(i), (2 + i) % 128);
            apply(v, m);
            chk("wrap_timeout", i, m.timeout, 0);
            chk("wrap_cpu_p_count", i, m.pst, 5);
            chk("wrap_rsp_count", i, m.rsp, 1);
            chk("wrap_xa_refresh", i, m.rfa, v.rfa);
        end

        // I/O write stalled in TW, then reset in the middle of it.
        @(negedge clk28);
        bus.cmd_op = 3'd4; bus.cmd_addr = 16'h001F; bus.cmd_wdata = 8'h99; bus.cmd_valid = 1'b1;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin @(negedge clk28); guard++; end
        @(negedge clk28);
        bus.cmd_valid = 1'b0;
        bus.n_wait = 1'b0;
        rsp_seen = 0;
        guard = 0;
        while (bus.n_iorq && guard < 100) begin @(negedge clk28); guard++; end
        chk("iow_started", 0, (guard < 100) ? 1 : 0, 1);
        repeat (20) begin
            @(negedge clk28);
            if (bus.rsp_valid) rsp_seen++;
        end
        chk("iow_tw_n_wr", 0, bus.n_wr, 0);
        chk("iow_tw_xd_oe", 0, bus.xd_oe, 1);
        rst = 1'b1;
        @(negedge clk28);
        chk("mid_rst_strobes", 0, int'({bus.n_mreq, bus.n_iorq, bus.n_rd, bus.n_wr, bus.n_m1, bus.n_rfsh}), 63);
        chk("mid_rst_xd_oe", 0, bus.xd_oe, 0);
        chk("mid_rst_xa", 0, int'(bus.xa), 0);
        chk("mid_rst_cmd_ready", 0, bus.cmd_ready, 0);
        if (bus.rsp_valid) rsp_seen++;
        rst = 1'b0;
        bus.n_wait = 1'b1;
        @(negedge clk28);
        if (bus.rsp_valid) rsp_seen++;
        chk("mid_rst_ready_after", 0, bus.cmd_ready, 1);
        chk("mid_rst_no_rsp", 0, rsp_seen, 0);
        chk("mid_rst_rsp_rdata", 0, int'(bus.rsp_rdata), 0);

        // After reset the refresh counter restarts at 0 and cycles run normally.
        v = mk(3'd0, 16'h0038, 8'h00, 8'hFF, 0, 0, 5, 16, 20, 0, 12, 0, 16, 0, 1, 8'hFF, 0);
        apply(v, m);
        check_vec(100, v, m);
        v = mk(3'd3, 16'h00FE, 8'h00, 8'hBF, 0, 0, 5, 0, 0, 20, 20, 0, 0, 0, 1, 8'hBF, -1);
        apply(v, m);
        check_vec(101, v, m);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
